// File: rtl/keypad_code_entry.sv
// Keypad code entry front-end: debounces keys, assembles a two-digit octal code,
// strobes it to the lock and classifies the lock's LED response.
module keypad_code_entry #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int ENTER_HOLD      = 2,
    parameter int RESP_TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       unlock_led,
    input  logic       error_led,
    input  logic       lockout_led,
    output logic [5:0] password_input,
    output logic       enter_button,
    output logic [1:0] digit_count,
    output logic       busy,
    output logic       reject,
    output logic       result_ok,
    output logic       result_fail,
    output logic       result_timeout
);

    // state     | meaning
    // IDLE      | no digits held, waiting for keys
    // ENTRY     | one or two digits held
    // SUBMIT    | enter_button asserted for ENTER_HOLD cycles
    // WAIT_RESP | waiting for an LED edge or the response timeout
    // LOCKOUT   | lock reports lockout; all keys rejected
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ENTRY     = 3'd1;
    localparam logic [2:0] ST_SUBMIT    = 3'd2;
    localparam logic [2:0] ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] ST_LOCKOUT   = 3'd4;

    logic [2:0] state;
    logic [3:0] deb_cnt;
    logic [3:0] deb_code;
    logic       armed;
    logic [3:0] deb_next;
    logic       key_accept;
    logic [3:0] hold_cnt;
    logic [7:0] resp_cnt;
    logic       unlock_prev;
    logic       error_prev;
    logic       lockout_prev;
    logic       unlock_rise;
    logic       error_rise;
    logic       lockout_rise;
    logic       is_digit;
    logic       is_clear;
    logic       is_submit;

    always_comb begin
        deb_next   = (deb_cnt != 4'd0 && key_code == deb_code) ? deb_cnt + 4'd1 : 4'd1;
        key_accept = key_valid && armed && (deb_next == 4'(DEBOUNCE_CYCLES));
    end

    assign is_digit     = (key_code < 4'd8);
    assign is_clear     = (key_code == 4'd8);
    assign is_submit    = (key_code == 4'd9);
    assign unlock_rise  = unlock_led && !unlock_prev;
    assign error_rise   = error_led && !error_prev;
    assign lockout_rise = lockout_led && !lockout_prev;
    assign busy         = (state == ST_SUBMIT) || (state == ST_WAIT_RESP) || (state == ST_LOCKOUT);

    // Re-arming needs key_valid low, which also covers the first press after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt  <= 4'd0;
            deb_code <= 4'd0;
            armed    <= 1'b0;
        end else if (!key_valid) begin
            deb_cnt <= 4'd0;
            armed   <= 1'b1;
        end else if (armed) begin
            if (key_accept) begin
                deb_cnt <= 4'd0;
                armed   <= 1'b0;
            end else begin
                deb_cnt  <= deb_next;
                deb_code <= key_code;
            end
        end else begin
            deb_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unlock_prev  <= 1'b0;
            error_prev   <= 1'b0;
            lockout_prev <= 1'b0;
        end else begin
            unlock_prev  <= unlock_led;
            error_prev   <= error_led;
            lockout_prev <= lockout_led;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            password_input <= 6'd0;
            digit_count    <= 2'd0;
            enter_button   <= 1'b0;
            hold_cnt       <= 4'd0;
            resp_cnt       <= 8'd0;
            reject         <= 1'b0;
            result_ok      <= 1'b0;
            result_fail    <= 1'b0;
            result_timeout <= 1'b0;
        end else begin
            reject         <= 1'b0;
            result_ok      <= 1'b0;
            result_fail    <= 1'b0;
            result_timeout <= 1'b0;
            if (state != ST_LOCKOUT && lockout_led) begin
                state          <= ST_LOCKOUT;
                password_input <= 6'd0;
                digit_count    <= 2'd0;
                enter_button   <= 1'b0;
                reject         <= key_accept;
                result_fail    <= (state == ST_WAIT_RESP) && lockout_rise;
            end else begin
                case (state)
                    ST_IDLE, ST_ENTRY: begin
                        if (key_accept) begin
                            if (is_digit) begin
                                if (digit_count < 2'd2) begin
                                    password_input <= {password_input[2:0], key_code[2:0]};
                                    digit_count    <= digit_count + 2'd1;
                                    state          <= ST_ENTRY;
                                end else begin
                                    reject <= 1'b1;
                                end
                            end else if (is_clear) begin
                                password_input <= 6'd0;
                                digit_count    <= 2'd0;
                                state          <= ST_IDLE;
                            end else if (is_submit && digit_count != 2'd0) begin
                                state        <= ST_SUBMIT;
                                enter_button <= 1'b1;
                                hold_cnt     <= 4'(ENTER_HOLD - 1);
                            end else begin
                                reject <= 1'b1;
                            end
                        end
                    end
                    ST_SUBMIT: begin
                        reject <= key_accept;
                        if (hold_cnt == 4'd0) begin
                            enter_button <= 1'b0;
                            resp_cnt     <= 8'(RESP_TIMEOUT);
                            state        <= ST_WAIT_RESP;
                        end else begin
                            hold_cnt <= hold_cnt - 4'd1;
                        end
                    end
                    ST_WAIT_RESP: begin
                        reject <= key_accept;
                        if (error_rise || unlock_rise || resp_cnt == 8'd1) begin
                            result_fail    <= error_rise;
                            result_ok      <= !error_rise && unlock_rise;
                            result_timeout <= !error_rise && !unlock_rise;
                            password_input <= 6'd0;
                            digit_count    <= 2'd0;
                            state          <= ST_IDLE;
                        end else begin
                            resp_cnt <= resp_cnt - 8'd1;
                        end
                    end
                    ST_LOCKOUT: begin
                        reject <= key_accept;
                        if (!lockout_led) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state          <= ST_IDLE;
                        password_input <= 6'd0;
                        digit_count    <= 2'd0;
                        enter_button   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
